// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS32 multiply/divide unit with HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [63:0] p;
    logic [31:0] a;
    logic [31:0] raw;
    logic        isdiv, negres, negrem, dzero;

    logic        accept, is_md, is_sgn, is_dv, fast_mul;
    logic [31:0] mag1, mag2;
    logic [32:0] msum;
    logic [33:0] ddiff;
    logic [31:0] drem;
    logic [63:0] mulstep, divstep, pneg;
    logic [31:0] fix_hi, fix_lo;

    assign busy   = (state != IDLE);
    assign accept = start & ~flush & (state == IDLE);
    assign is_md  = ~op[2];
    assign is_sgn = ~op[0];
    assign is_dv  = op[1];
    assign mag1   = (is_sgn & src1[31]) ? (32'd0 - src1) : src1;
    assign mag2   = (is_sgn & src2[31]) ? (32'd0 - src2) : src2;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = is_md & ~is_dv;
`else
    assign fast_mul = 1'b0;
`endif

    // One shift-add or restoring-divide step on the shared 64-bit register
    always_comb begin
        msum    = {1'b0, p[63:32]} + {1'b0, (p[0] ? a : 32'd0)};
        mulstep = {msum, p[31:1]};
        ddiff   = {1'b0, p[63:32], p[31]} - {2'b00, a};
        drem    = ddiff[33] ? {p[62:32], p[31]} : ddiff[31:0];
        divstep = {drem, p[30:0], ~ddiff[33]};
    end

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        pneg = 64'd0 - p;
        if (!isdiv) begin
            fix_hi = negres ? pneg[63:32] : p[63:32];
            fix_lo = negres ? pneg[31:0] : p[31:0];
        end else if (dzero) begin
            fix_hi = raw;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            fix_hi = negrem ? (32'd0 - p[63:32]) : p[63:32];
            fix_lo = negres ? (32'd0 - p[31:0]) : p[31:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; flush overrides everything but reset
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && is_md) state_nx = fast_mul ? FIX : RUN;
            RUN:  if (cnt == 5'd31) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Operand latch, iteration datapath, HI/LO writes and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 5'd0;
            p      <= 64'd0;
            a      <= 32'd0;
            raw    <= 32'd0;
            isdiv  <= 1'b0;
            negres <= 1'b0;
            negrem <= 1'b0;
            dzero  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        a      <= mag2;
                        raw    <= src1;
                        isdiv  <= is_dv;
                        negres <= is_sgn & (src1[31] ^ src2[31]);
                        negrem <= is_sgn & src1[31];
                        dzero  <= (src2 == 32'd0);
                        cnt    <= 5'd0;
                        p      <= {32'd0, mag1};
`ifdef MULDIV_FAST_MUL_EN
                        if (fast_mul)
                            p <= {32'd0, mag1} * {32'd0, mag2};
`endif
                    end else if (accept && op == 3'b100) begin
                        hi <= src1;
                    end else if (accept && op == 3'b101) begin
                        lo <= src1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    p   <= isdiv ? divstep : mulstep;
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, random ops vs. arithmetic model,
// plus handshake, flush and reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MULBUSY = 1;
`else
    localparam int MULBUSY = 33;
`endif

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src1(src1), .src2(src2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  o;
        logic [31:0] s1, s2, ehi, elo;
    } vec_t;

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction

    // Architectural result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_op(input logic [2:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy;
        int q, m;
        logic [63:0] r;
        sx = longint'(int'(x));
        sy = longint'(int'(y));
        r = 64'd0;
        case (o)
            3'd0: r = 64'(sx * sy);
            3'd1: r = {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else begin
                    q = int'(x) / int'(y);
                    m = int'(x) % int'(y);
                    r = {32'(m), 32'(q)};
                end
            end
            3'd3: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [63:0] res,
                          output int nbusy);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; src1 = x; src2 = y;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        cyc = 0;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 64'(cyc < 100), 64'd1);
        res = {hi, lo};
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    vec_t vt[7];
    logic [63:0] res, exp;
    int nb;

    initial begin
        vt[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vt[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vt[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[3] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        vt[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        vt[5] = '{3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF};
        vt[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].o, vt[i].s1, vt[i].s2, res, nb);
            check($sformatf("vec%0d_hilo", i), res, {vt[i].ehi, vt[i].elo});
            check($sformatf("vec%0d_busy", i), 64'(nb),
                  64'(vt[i].o[1] ? 33 : MULBUSY));
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 3));
            x = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20))
                                            : 32'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if (i % 3 == 0) y = 32'($urandom_range(1, 9));
            run_op(o, x, y, res, nb);
            exp = ref_op(o, x, y);
            check($sformatf("rnd%0d_op%0d", i, o), res, exp);
        end

        @(negedge clk);
        start = 1'b1; op = 3'd4; src1 = 32'hA5A5_A5A5;
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
        check("mthi_busy", 64'({busy, done}), 64'd0);
        op = 3'd5; src1 = 32'h5A5A_5A5A;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h5A5A_5A5A);
        check("mtlo_hi", 64'(hi), 64'hA5A5_A5A5);
        check("mtlo_busy", 64'({busy, done}), 64'd0);
        op = 3'd7;
        @(negedge clk);
        check("noop_keep", 64'(busy), 64'd0);

        start = 1'b1; op = 3'd3; src1 = 32'd100; src2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        begin
            int sawdone = 0;
            for (int c = 1; c < 45; c++) begin
                if (c == 10) begin
                    start = 1'b1; op = 3'd0;
                    src1 = 32'd3; src2 = 32'd3;
                end else start = 1'b0;
                flush = (c == 20);
                if (c == 21) begin
                    check("flush_busy", 64'(busy), 64'd0);
                    check("flush_hilo", {hi, lo},
                          {32'hA5A5_A5A5, 32'h5A5A_5A5A});
                end
                if (done) sawdone++;
                @(negedge clk);
            end
            flush = 1'b0;
            check("flush_nodone", 64'(sawdone), 64'd0);
            check("flush_hilo_late", {hi, lo},
                  {32'hA5A5_A5A5, 32'h5A5A_5A5A});
        end

        start = 1'b1; op = 3'd3; src1 = 32'd100; src2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        check("fix_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fixflush_busy", 64'({busy, done}), 64'd0);
        check("fixflush_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});
        @(negedge clk);
        check("fixflush_done", 64'(done), 64'd0);

        start = 1'b1; op = 3'd2; src1 = 32'd1000; src2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'({busy, done}), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        run_op(3'd0, 32'hFFFF_FFF9, 32'd6, res, nb);
        check("postrst_mult", res, ref_op(3'd0, 32'hFFFF_FFF9, 32'd6));
        check("postrst_busy", 64'(nb), 64'(MULBUSY));

        start = 1'b1; op = 3'd3; src1 = 32'd50; src2 = 32'd8;
        @(negedge clk);
        start = 1'b0;
        begin
            int c = 0;
            while (!done && c < 100) begin
                @(negedge clk);
                c++;
            end
            check("b2b_first", {hi, lo}, {32'd2, 32'd6});
            start = 1'b1; op = 3'd3; src1 = 32'd9; src2 = 32'd4;
            @(negedge clk);
            start = 1'b0;
            check("b2b_accept", 64'(busy), 64'd1);
            c = 0;
            while (!done && c < 100) begin
                @(negedge clk);
                c++;
            end
            check("b2b_latency", 64'(c), 64'd33);
            check("b2b_second", {hi, lo}, {32'd1, 32'd2});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
